// File: rtl/video_in_pkg.sv
// Shared defaults, FSM state and descriptor types for the video_in line RAM write side.
package video_in_pkg;

  localparam int unsigned DEF_ADDR_SIZE = 6;
  localparam int unsigned DEF_DATA_SIZE = 32;
  localparam int unsigned DEF_PIX_SIZE  = 8;

  typedef enum logic [1:0] {
    WAIT_LINE,
    FILL,
    FLUSH,
    DROP
  } lp_state_t;

  // One closed RAM half as handed to the reader.
  typedef struct packed {
    logic                     id;
    logic [DEF_ADDR_SIZE-1:0] words;
    logic                     sof;
    logic                     eol;
  } buf_desc_t;

endpackage

// File: rtl/video_in_desc_fifo.sv
// Two-entry descriptor queue; simultaneous push and pop are both honoured.
module video_in_desc_fifo
  import video_in_pkg::*;
#(
  parameter type desc_t = buf_desc_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  desc_t push_desc,
  input  logic  pop,
  output desc_t head,
  output logic  full,
  output logic  empty
);

  desc_t      mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_desc;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/video_in_line_packer.sv
// Packs the incoming pixel stream into RAM words, writes them through port A and hands each
// closed ping-pong half to the reader as a descriptor.
module video_in_line_packer
  import video_in_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned PIX_SIZE  = DEF_PIX_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_valid,
  input  logic                 line_valid,
  input  logic [PIX_SIZE-1:0]  pix_in,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [DATA_SIZE-1:0] ram_wdata,
  output logic                 ram_we,
  output logic                 buf_valid,
  output logic                 buf_id,
  output logic [ADDR_SIZE-1:0] buf_words,
  output logic                 buf_sof,
  output logic                 buf_eol,
  input  logic                 buf_release,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam int unsigned PPW  = DATA_SIZE / PIX_SIZE;
  localparam int unsigned HALF = 2 ** (ADDR_SIZE - 1);
  localparam int unsigned CW   = (PPW > 1) ? $clog2(PPW) : 1;

  if (DATA_SIZE % PIX_SIZE != 0) begin : g_bad_ppw
    $error("DATA_SIZE must be a multiple of PIX_SIZE");
  end
  if (ADDR_SIZE < 2) begin : g_bad_addr
    $error("ADDR_SIZE must be at least 2");
  end

  typedef struct packed {
    logic                 id;
    logic [ADDR_SIZE-1:0] words;
    logic                 sof;
    logic                 eol;
  } desc_t;

  lp_state_t            state_q, state_d;
  logic                 line_prev_q, frame_prev_q;
  logic                 half_q, half_d;
  logic [1:0]           busy_q, busy_d;
  logic [ADDR_SIZE-1:0] word_idx_q, word_idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] pack_q, pack_d;
  logic                 ram_we_q, ram_we_d;
  logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_SIZE-1:0] ram_wdata_q, ram_wdata_d;
  logic                 close_q, close_d;
  desc_t                close_desc_q, close_desc_d;
  logic                 sof_pend_q, sof_pend_d;
  logic                 overflow_q, overflow_d;

  logic                 pix_ok;
  logic                 line_rise;
  logic                 frame_rise;
  logic                 accept;
  logic                 overflow_set;
  logic                 close_now;
  logic                 close_eol;
  logic [ADDR_SIZE-1:0] close_words;
  logic [DATA_SIZE-1:0] word_next;
  logic                 pop;
  desc_t                head;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign pix_ok     = line_valid && frame_valid;
  assign line_rise  = line_valid && !line_prev_q;
  assign frame_rise = frame_valid && !frame_prev_q;
  assign word_next  = pack_q | (DATA_SIZE'(pix_in) << (PIX_SIZE * 32'(cnt_q)));
  assign pop        = buf_valid && buf_release;

  // Line FSM, packer, write port and half bookkeeping.
  always_comb begin
    state_d      = state_q;
    half_d       = half_q;
    busy_d       = busy_q;
    word_idx_d   = word_idx_q;
    cnt_d        = cnt_q;
    pack_d       = pack_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    close_d      = 1'b0;
    close_desc_d = close_desc_q;
    sof_pend_d   = sof_pend_q;
    accept       = 1'b0;
    overflow_set = 1'b0;
    close_now    = 1'b0;
    close_eol    = 1'b0;
    close_words  = word_idx_q;

    unique case (state_q)
      WAIT_LINE: begin
        if (line_rise && frame_valid) begin
          if (busy_q[half_q]) begin
            state_d      = DROP;
            overflow_set = 1'b1;
          end else begin
            state_d = FILL;
            accept  = 1'b1;
          end
        end
      end
      FILL: begin
        if (pix_ok) begin
          accept = 1'b1;
        end else if (cnt_q != '0 || word_idx_q != '0) begin
          // Line (or frame) ended: emit the zero-padded partial word and close with eol.
          state_d     = FLUSH;
          close_now   = 1'b1;
          close_eol   = 1'b1;
          close_words = word_idx_q + ADDR_SIZE'(cnt_q != '0);
          if (cnt_q != '0) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = {half_q, word_idx_q[ADDR_SIZE-2:0]};
            ram_wdata_d = pack_q;
          end
        end else begin
          // Line ended exactly on a half boundary; that half is already closed.
          state_d = WAIT_LINE;
        end
      end
      FLUSH: begin
        state_d = WAIT_LINE;
      end
      DROP: begin
        if (!line_valid) begin
          state_d = WAIT_LINE;
        end
      end
    endcase

    if (accept) begin
      if (cnt_q == CW'(PPW - 1)) begin
        ram_we_d    = 1'b1;
        ram_addr_d  = {half_q, word_idx_q[ADDR_SIZE-2:0]};
        ram_wdata_d = word_next;
        cnt_d       = '0;
        pack_d      = '0;
        word_idx_d  = word_idx_q + ADDR_SIZE'(1);
        if (word_idx_q == ADDR_SIZE'(HALF - 1)) begin
          close_now   = 1'b1;
          close_words = ADDR_SIZE'(HALF);
          if (busy_q[~half_q]) begin
            state_d      = DROP;
            overflow_set = 1'b1;
          end
        end
      end else begin
        pack_d = word_next;
        cnt_d  = cnt_q + CW'(1);
      end
    end

    if (pop) begin
      busy_d[head.id] = 1'b0;
    end

    // The descriptor is pushed one cycle later, once its last word is on the RAM port.
    if (close_now) begin
      close_d            = 1'b1;
      close_desc_d.id    = half_q;
      close_desc_d.words = close_words;
      close_desc_d.sof   = sof_pend_q;
      close_desc_d.eol   = close_eol;
      busy_d[half_q]     = 1'b1;
      half_d             = ~half_q;
      word_idx_d         = '0;
      cnt_d              = '0;
      pack_d             = '0;
      sof_pend_d         = 1'b0;
    end

    if (frame_rise) begin
      sof_pend_d = 1'b1;
    end

    if (close_q && fifo_full && !pop) begin
      overflow_set = 1'b1;
    end

    if (overflow_set) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers; line_prev starts high so a line already active at reset release is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LINE;
      line_prev_q  <= 1'b1;
      frame_prev_q <= 1'b0;
      half_q       <= 1'b0;
      busy_q       <= 2'b00;
      word_idx_q   <= '0;
      cnt_q        <= '0;
      pack_q       <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      close_q      <= 1'b0;
      close_desc_q <= '0;
      sof_pend_q   <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_prev_q  <= line_valid;
      frame_prev_q <= frame_valid;
      half_q       <= half_d;
      busy_q       <= busy_d;
      word_idx_q   <= word_idx_d;
      cnt_q        <= cnt_d;
      pack_q       <= pack_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      close_q      <= close_d;
      close_desc_q <= close_desc_d;
      sof_pend_q   <= sof_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  video_in_desc_fifo #(
    .desc_t (desc_t)
  ) u_desc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (close_q),
    .push_desc (close_desc_q),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign overflow  = overflow_q;
  assign buf_valid = !fifo_empty;
  assign buf_id    = buf_valid ? head.id : 1'b0;
  assign buf_words = buf_valid ? head.words : '0;
  assign buf_sof   = buf_valid ? head.sof : 1'b0;
  assign buf_eol   = buf_valid ? head.eol : 1'b0;

endmodule

// File: tb/tb_video_in_line_packer.sv
// Directed bench for video_in_line_packer (HALF=32, PPW=4).
module tb_video_in_line_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_valid;
  logic        line_valid;
  logic [7:0]  pix_in;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        buf_valid;
  logic        buf_id;
  logic [5:0]  buf_words;
  logic        buf_sof;
  logic        buf_eol;
  logic        buf_release;
  logic        overflow;
  logic        clr_overflow;

  int total = 0;
  int bad   = 0;

  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [8:0]  dq[$];  // {id, words, sof, eol}

  typedef struct {
    int          npix;
    logic [7:0]  base;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  video_in_line_packer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_valid  (frame_valid),
    .line_valid   (line_valid),
    .pix_in       (pix_in),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .buf_valid    (buf_valid),
    .buf_id       (buf_id),
    .buf_words    (buf_words),
    .buf_sof      (buf_sof),
    .buf_eol      (buf_eol),
    .buf_release  (buf_release),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Log RAM writes and popped descriptors mid-cycle.
  always @(negedge clk) begin
    if (ram_we) begin
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_wdata);
    end
    if (buf_valid && buf_release) begin
      dq.push_back({buf_id, buf_words, buf_sof, buf_eol});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    dq.delete();
  endtask

  task automatic drive_line(input int npix, input logic [7:0] base);
    for (int i = 0; i < npix; i++) begin
      line_valid = 1'b1;
      pix_in     = 8'(base + 8'(i));
      step(1);
    end
    line_valid = 1'b0;
    pix_in     = 8'h00;
  endtask

  task automatic release_one();
    buf_release = 1'b1;
    step(1);
    buf_release = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    frame_valid  = 1'b0;
    line_valid   = 1'b0;
    pix_in       = 8'h00;
    buf_release  = 1'b0;
    clr_overflow = 1'b0;

    vecs[0] = '{npix: 8, base: 8'h01, nwr: 2, w0: 32'h04030201, w1: 32'h08070605};
    vecs[1] = '{npix: 6, base: 8'h01, nwr: 2, w0: 32'h04030201, w1: 32'h00000605};
    vecs[2] = '{npix: 3, base: 8'hA0, nwr: 1, w0: 32'h00A2A1A0, w1: 32'h0};
    vecs[3] = '{npix: 5, base: 8'h10, nwr: 2, w0: 32'h13121110, w1: 32'h00000014};
    vecs[4] = '{npix: 4, base: 8'hF0, nwr: 1, w0: 32'hF3F2F1F0, w1: 32'h0};

    // Reset state
    do_reset();
    chk("rst ram_we", 64'(ram_we), 64'd0);
    chk("rst ram_addr", 64'(ram_addr), 64'd0);
    chk("rst ram_wdata", 64'(ram_wdata), 64'd0);
    chk("rst buf_valid", 64'(buf_valid), 64'd0);
    chk("rst buf_words", 64'(buf_words), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);

    // Table: single lines into a freshly reset block, reader releasing immediately
    for (int v = 0; v < 5; v++) begin
      do_reset();
      frame_valid = 1'b1;
      buf_release = 1'b1;
      step(2);
      clear_logs();
      drive_line(vecs[v].npix, vecs[v].base);
      step(5);
      buf_release = 1'b0;
      chk($sformatf("v%0d nwrites", v), 64'(wa_q.size()), 64'(vecs[v].nwr));
      if (wa_q.size() > 0) begin
        chk($sformatf("v%0d addr0", v), 64'(wa_q[0]), 64'd0);
        chk($sformatf("v%0d data0", v), 64'(wd_q[0]), 64'(vecs[v].w0));
      end
      if (vecs[v].nwr > 1 && wa_q.size() > 1) begin
        chk($sformatf("v%0d addr1", v), 64'(wa_q[1]), 64'd1);
        chk($sformatf("v%0d data1", v), 64'(wd_q[1]), 64'(vecs[v].w1));
      end
      chk($sformatf("v%0d ndesc", v), 64'(dq.size()), 64'd1);
      if (dq.size() > 0) begin
        chk($sformatf("v%0d desc", v), 64'(dq[0]), 64'({1'b0, 6'(vecs[v].nwr), 1'b1, 1'b1}));
      end
      frame_valid = 1'b0;
    end

    // Long line: 72 words across half0, half1, half0
    do_reset();
    frame_valid = 1'b1;
    buf_release = 1'b1;
    step(2);
    clear_logs();
    drive_line(288, 8'h00);
    step(6);
    buf_release = 1'b0;
    chk("long nwrites", 64'(wa_q.size()), 64'd72);
    for (int k = 0; k < 72 && k < wa_q.size(); k++) begin
      chk($sformatf("long addr%0d", k), 64'(wa_q[k]), 64'((k < 64) ? k : k - 64));
      chk($sformatf("long data%0d", k), 64'(wd_q[k]),
          64'({8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)}));
    end
    chk("long ndesc", 64'(dq.size()), 64'd3);
    if (dq.size() == 3) begin
      chk("long desc0", 64'(dq[0]), 64'({1'b0, 6'd32, 1'b1, 1'b0}));
      chk("long desc1", 64'(dq[1]), 64'({1'b1, 6'd32, 1'b0, 1'b0}));
      chk("long desc2", 64'(dq[2]), 64'({1'b0, 6'd8, 1'b0, 1'b1}));
    end
    frame_valid = 1'b0;

    // Frame ends mid-line: treated as a line end
    do_reset();
    frame_valid = 1'b1;
    buf_release = 1'b1;
    step(2);
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      line_valid = 1'b1;
      pix_in     = 8'(i + 1);
      step(1);
    end
    frame_valid = 1'b0;
    step(1);
    line_valid = 1'b0;
    step(5);
    buf_release = 1'b0;
    chk("fcut nwrites", 64'(wa_q.size()), 64'd2);
    if (wa_q.size() == 2) begin
      chk("fcut data1", 64'(wd_q[1]), 64'h00000005);
    end
    chk("fcut ndesc", 64'(dq.size()), 64'd1);
    if (dq.size() > 0) begin
      chk("fcut desc", 64'(dq[0]), 64'({1'b0, 6'd2, 1'b1, 1'b1}));
    end

    // No release: two halves queued, third line dropped
    do_reset();
    frame_valid = 1'b1;
    step(2);
    clear_logs();
    drive_line(8, 8'h01);
    step(3);
    drive_line(8, 8'h11);
    step(3);
    chk("q2 valid", 64'(buf_valid), 64'd1);
    chk("q2 head", 64'({buf_id, buf_words, buf_sof, buf_eol}), 64'({1'b0, 6'd2, 1'b1, 1'b1}));
    chk("q2 ovf before", 64'(overflow), 64'd0);
    clear_logs();
    drive_line(8, 8'h21);
    step(3);
    chk("drop nwrites", 64'(wa_q.size()), 64'd0);
    chk("drop overflow", 64'(overflow), 64'd1);
    chk("drop head", 64'({buf_id, buf_words}), 64'({1'b0, 6'd2}));
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    chk("clr overflow", 64'(overflow), 64'd0);
    release_one();
    chk("q2 second", 64'({buf_valid, buf_id, buf_words, buf_sof, buf_eol}),
        64'({1'b1, 1'b1, 6'd2, 1'b0, 1'b1}));
    release_one();
    chk("q2 drained", 64'(buf_valid), 64'd0);

    // Release on the cycle a new half closes
    do_reset();
    frame_valid = 1'b1;
    step(2);
    drive_line(8, 8'h01);
    step(3);
    drive_line(6, 8'h31);
    step(1);
    chk("sim flush we", 64'(ram_we), 64'd1);
    chk("sim flush addr", 64'(ram_addr), 64'd33);
    chk("sim flush data", 64'(ram_wdata), 64'h00003635);
    buf_release = 1'b1;
    step(1);
    buf_release = 1'b0;
    chk("sim head", 64'({buf_valid, buf_id, buf_words, buf_sof, buf_eol}),
        64'({1'b1, 1'b1, 6'd2, 1'b0, 1'b1}));
    release_one();
    chk("sim count", 64'(buf_valid), 64'd0);
    clear_logs();
    drive_line(4, 8'h41);
    step(3);
    chk("sim next n", 64'(wa_q.size()), 64'd1);
    if (wa_q.size() > 0) begin
      chk("sim next addr", 64'(wa_q[0]), 64'd0);
      chk("sim next data", 64'(wd_q[0]), 64'h44434241);
    end

    // Reset in the middle of a line
    do_reset();
    frame_valid = 1'b1;
    buf_release = 1'b1;
    step(2);
    clear_logs();
    line_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix_in = 8'(8'h61 + 8'(i));
      step(1);
    end
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix_in = 8'(8'h70 + 8'(i));
      step(1);
    end
    line_valid = 1'b0;
    step(4);
    chk("rstmid nwrites", 64'(wa_q.size()), 64'd0);
    chk("rstmid ndesc", 64'(dq.size()), 64'd0);
    drive_line(4, 8'h51);
    step(5);
    buf_release = 1'b0;
    chk("rstmid next n", 64'(wa_q.size()), 64'd1);
    if (wa_q.size() > 0) begin
      chk("rstmid next addr", 64'(wa_q[0]), 64'd0);
      chk("rstmid next data", 64'(wd_q[0]), 64'h54535251);
    end
    chk("rstmid ndesc2", 64'(dq.size()), 64'd1);
    if (dq.size() > 0) begin
      chk("rstmid desc", 64'(dq[0]), 64'({1'b0, 6'd1, 1'b1, 1'b1}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
